// File: rtl/function_decoder_pkg.sv
// Shared definitions for the function decoder: function codes, one-hot op
// indices, FSM state encoding and the default store line width.
package instruction_pkg;

    localparam int LINE_BITS_DEF = 5;

    localparam logic [2:0] FN_JMP     = 3'd0;
    localparam logic [2:0] FN_JRP     = 3'd1;
    localparam logic [2:0] FN_LDN     = 3'd2;
    localparam logic [2:0] FN_STO     = 3'd3;
    localparam logic [2:0] FN_SUB     = 3'd4;
    localparam logic [2:0] FN_SUB_ALT = 3'd5;
    localparam logic [2:0] FN_CMP     = 3'd6;
    localparam logic [2:0] FN_STP     = 3'd7;

    localparam int OP_JMP = 0;
    localparam int OP_JRP = 1;
    localparam int OP_LDN = 2;
    localparam int OP_STO = 3;
    localparam int OP_SUB = 4;
    localparam int OP_CMP = 6;
    localparam int OP_STP = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_DONE   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

endpackage

// File: rtl/function_decoder_if.sv
// Signal bundle between the staticisor/beat timing/execution side (master)
// and the function decoder (slave); dbg_state exposes the decoder FSM.
interface function_decoder_if #(
    parameter int WIDTH     = 8,
    parameter int LINE_BITS = 5
);
    import instruction_pkg::*;

    // ready is a clock enable for the whole decoder. w_EXEC is a one-cycle start
    // strobe; w_EXEC_done is a completion pulse accepted only while the decoder is
    // in EXEC (including the cycle w_EXEC is high) on a ready cycle.
    logic                 ready;
    logic                 w_HA;
    logic [WIDTH-1:0]     b_STAT_in;
    logic                 w_ACC_NEG;
    logic                 w_EXEC_done;
    logic                 w_RESUME;
    logic [LINE_BITS-1:0] b_LINE_out;
    logic [7:0]           b_OP_out;
    logic                 w_EXEC;
    logic                 w_STORE_WE;
    logic                 w_SKIP;
    logic                 w_HALT;
    logic                 w_FAULT;
    state_t               dbg_state;

    modport master (
        output ready, w_HA, b_STAT_in, w_ACC_NEG, w_EXEC_done, w_RESUME,
        input  b_LINE_out, b_OP_out, w_EXEC, w_STORE_WE, w_SKIP, w_HALT, w_FAULT, dbg_state
    );

    modport slave (
        input  ready, w_HA, b_STAT_in, w_ACC_NEG, w_EXEC_done, w_RESUME,
        output b_LINE_out, b_OP_out, w_EXEC, w_STORE_WE, w_SKIP, w_HALT, w_FAULT, dbg_state
    );

endinterface

// File: rtl/function_decoder_func_onehot.sv
// 3-to-8 function decode. F=5 aliases SUB unless FUNC_ILLEGAL_TRAP_EN is
// defined, in which case it yields no op and raises o_illegal.
module func_onehot
    import instruction_pkg::*;
(
    input  logic [2:0] i_func,
    output logic [7:0] o_op,
    output logic       o_illegal
);

    always_comb begin
        o_op      = 8'b0;
        o_illegal = 1'b0;
        case (i_func)
            FN_SUB_ALT: begin
`ifdef FUNC_ILLEGAL_TRAP_EN
                o_illegal = 1'b1;
`else
                o_op[OP_SUB] = 1'b1;
`endif
            end
            default: o_op[i_func] = 1'b1;
        endcase
    end

endmodule

// File: rtl/function_decoder.sv
// Function decoder: captures the staticised word at the start of the action
// phase, issues one-hot op strobes and sequences execution, skip and halt.
module function_decoder
    import instruction_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LINE_BITS = LINE_BITS_DEF,
    parameter int FUNC_BITS = 3,
    parameter int TIMEOUT   = 15
) (
    input logic               w_CLK,
    input logic               w_RST,
    function_decoder_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    if (FUNC_BITS != 3 || WIDTH != LINE_BITS + FUNC_BITS) begin : g_bad_cfg
        $error("function_decoder: FUNC_BITS must be 3 and WIDTH must equal LINE_BITS + 3");
    end

    state_t               r_state, w_state_nx;
    logic                 r_ha_prev;
    logic [WIDTH-1:0]     r_word, w_word_nx;
    logic [LINE_BITS-1:0] r_line, w_line_nx;
    logic [7:0]           r_op, w_op_nx, w_dec_op;
    logic                 r_exec, w_exec_nx;
    logic                 r_we, w_we_nx;
    logic                 r_skip, w_skip_nx;
    logic                 r_halt, w_halt_nx;
    logic                 r_fault, w_fault_nx;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
    logic                 w_illegal;

    func_onehot u_func_onehot (
        .i_func    (r_word[WIDTH-1:LINE_BITS]),
        .o_op      (w_dec_op),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_state_nx = r_state;
        w_word_nx  = r_word;
        w_line_nx  = r_line;
        w_op_nx    = r_op;
        w_exec_nx  = 1'b0;
        w_we_nx    = r_we;
        w_skip_nx  = r_skip;
        w_halt_nx  = r_halt;
        w_fault_nx = r_fault;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.w_HA && !r_ha_prev) begin
                    w_word_nx  = bus.b_STAT_in;
                    w_state_nx = ST_LATCH;
                end
            end
            ST_LATCH: begin
                w_line_nx = r_word[LINE_BITS-1:0];
                w_op_nx   = w_dec_op;
                w_skip_nx = 1'b0;
                w_cnt_nx  = '0;
                if (w_illegal) begin
                    w_state_nx = ST_HALTED;
                    w_halt_nx  = 1'b1;
                    w_fault_nx = 1'b1;
                end else if (w_dec_op[OP_STP]) begin
                    w_state_nx = ST_HALTED;
                    w_halt_nx  = 1'b1;
                end else begin
                    w_state_nx = ST_EXEC;
                    w_exec_nx  = 1'b1;
                    w_we_nx    = w_dec_op[OP_STO];
                end
            end
            ST_EXEC: begin
                // CMP never waits for the execution unit; done wins over timeout.
                if (r_op[OP_CMP]) begin
                    w_skip_nx  = bus.w_ACC_NEG;
                    w_state_nx = ST_DONE;
                end else if (bus.w_EXEC_done) begin
                    w_state_nx = ST_DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nx = ST_DONE;
                    w_fault_nx = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
                if (w_state_nx == ST_DONE) begin
                    w_op_nx = 8'b0;
                    w_we_nx = 1'b0;
                end
            end
            ST_DONE: begin
                if (!bus.w_HA) begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (bus.w_RESUME) begin
                    w_state_nx = ST_DONE;
                    w_halt_nx  = 1'b0;
                    w_op_nx    = 8'b0;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            r_state   <= ST_IDLE;
            r_ha_prev <= 1'b0;
            r_word    <= '0;
            r_line    <= '0;
            r_op      <= '0;
            r_exec    <= 1'b0;
            r_we      <= 1'b0;
            r_skip    <= 1'b0;
            r_halt    <= 1'b0;
            r_fault   <= 1'b0;
            r_cnt     <= '0;
        end else if (bus.ready) begin
            r_state   <= w_state_nx;
            r_ha_prev <= bus.w_HA;
            r_word    <= w_word_nx;
            r_line    <= w_line_nx;
            r_op      <= w_op_nx;
            r_exec    <= w_exec_nx;
            r_we      <= w_we_nx;
            r_skip    <= w_skip_nx;
            r_halt    <= w_halt_nx;
            r_fault   <= w_fault_nx;
            r_cnt     <= w_cnt_nx;
        end
    end

    assign bus.b_LINE_out = r_line;
    assign bus.b_OP_out   = r_op;
    assign bus.w_EXEC     = r_exec;
    assign bus.w_STORE_WE = r_we;
    assign bus.w_SKIP     = r_skip;
    assign bus.w_HALT     = r_halt;
    assign bus.w_FAULT    = r_fault;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_function_decoder.sv
// Directed plus randomized checks of function_decoder against a transaction-level
// model of the action phase (latch, execute, complete, halt/resume).
module tb_function_decoder;
    import instruction_pkg::*;

    logic w_CLK = 1'b0;
    logic w_RST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic       m_exec, m_we, m_skip, m_halt, m_fault;
    logic [7:0] m_op;
    logic [4:0] m_line;

    function_decoder_if #(.WIDTH(8), .LINE_BITS(5)) bus ();

    function_decoder #(.WIDTH(8), .LINE_BITS(5), .FUNC_BITS(3), .TIMEOUT(15)) dut (
        .w_CLK (w_CLK),
        .w_RST (w_RST),
        .bus   (bus)
    );

    always #5 w_CLK = ~w_CLK;

    task automatic tick();
        @(posedge w_CLK);
        #1;
    endtask

    function automatic logic [7:0] model_op(input int f);
        logic [7:0] one;
        one = 8'd1;
        if (f == 5) begin
`ifdef FUNC_ILLEGAL_TRAP_EN
            return 8'h00;
`else
            return 8'h10;
`endif
        end
        return one << f;
    endfunction

    task automatic check(input string tag);
        logic [31:0] obs, exp;
        obs = {14'd0, bus.w_EXEC, bus.w_STORE_WE, bus.w_SKIP, bus.w_HALT, bus.w_FAULT,
               bus.b_OP_out, bus.b_LINE_out};
        exp = {14'd0, m_exec, m_we, m_skip, m_halt, m_fault, m_op, m_line};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got exec/we/skip/halt/fault/op/line=%05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input state_t exp);
        logic [2:0] obs;
        obs = bus.dbg_state;
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got state %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_exec = 1'b0; m_we = 1'b0; m_skip = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
        m_op = 8'h00; m_line = 5'd0;
    endtask

    // One action phase; delay >= 15 withholds done entirely. Returns early when halted.
    task automatic run_op(input int line, input int f, input bit neg, input int delay,
                          input bit drop, input bit stall);
        bit trap;
`ifdef FUNC_ILLEGAL_TRAP_EN
        trap = (f == 5);
`else
        trap = 1'b0;
`endif
        bus.b_STAT_in = 8'((f << 5) | line);
        bus.w_ACC_NEG = neg;
        bus.w_HA = 1'b1;
        tick();
        m_exec = 1'b0;
        check("latch");
        tick();
        m_line = 5'(line);
        m_skip = 1'b0;
        m_op = model_op(f);
        if (trap || f == 7) begin
            m_halt = 1'b1;
            if (trap) m_fault = 1'b1;
            check("halt_entry");
            check_state("halt_state", ST_HALTED);
            return;
        end
        m_exec = 1'b1;
        m_we = (f == 3);
        check("exec_start");
        if (drop) bus.w_HA = 1'b0;
        if (stall) begin
            bus.ready = 1'b0;
            bus.w_EXEC_done = 1'b1;
            repeat (3) begin
                tick();
                check("stall_frozen");
            end
            bus.w_EXEC_done = 1'b0;
            bus.ready = 1'b1;
        end
        if (f == 6) begin
            tick();
            m_exec = 1'b0; m_op = 8'h00; m_skip = neg;
            check("cmp_done");
        end else begin
            for (int i = 0; i < delay && i < 15; i++) begin
                tick();
                m_exec = 1'b0;
                if (i == 14) begin
                    m_op = 8'h00; m_we = 1'b0; m_fault = 1'b1;
                end
                check("exec_wait");
            end
            if (delay < 15) begin
                bus.w_EXEC_done = 1'b1;
                tick();
                bus.w_EXEC_done = 1'b0;
                m_exec = 1'b0; m_op = 8'h00; m_we = 1'b0;
                check("exec_done");
            end
        end
        if (!drop) begin
            tick();
            check("no_rerun");
        end
        bus.w_HA = 1'b0;
        tick();
        check("phase_end");
        check_state("idle_again", ST_IDLE);
    endtask

    task automatic do_resume();
        bus.w_RESUME = 1'b1;
        tick();
        bus.w_RESUME = 1'b0;
        m_halt = 1'b0; m_op = 8'h00; m_exec = 1'b0;
        check("resume");
        bus.w_HA = 1'b0;
        tick();
        check("after_resume");
        check_state("resume_idle", ST_IDLE);
    endtask

    initial begin
        bus.ready = 1'b1;
        bus.w_HA = 1'b0;
        bus.b_STAT_in = 8'h00;
        bus.w_ACC_NEG = 1'b0;
        bus.w_EXEC_done = 1'b0;
        bus.w_RESUME = 1'b0;
        model_reset();

        tick();
        tick();
        check("reset_outputs");
        check_state("reset_state", ST_IDLE);
        w_RST = 1'b0;

        bus.w_EXEC_done = 1'b1;
        tick();
        bus.w_EXEC_done = 1'b0;
        check("done_in_idle_ignored");
        bus.w_RESUME = 1'b1;
        tick();
        bus.w_RESUME = 1'b0;
        check("resume_in_idle_ignored");

        run_op(0, 0, 1'b0, 1, 1'b0, 1'b0);
        run_op(0, 0, 1'b0, 0, 1'b0, 1'b0);
        run_op(13, 3, 1'b0, 4, 1'b0, 1'b0);
        run_op(9, 6, 1'b1, 0, 1'b0, 1'b0);
        run_op(9, 6, 1'b0, 0, 1'b0, 1'b0);

        run_op(21, 7, 1'b0, 0, 1'b0, 1'b0);
        repeat (3) begin
            bus.w_HA = 1'b0;
            tick();
            bus.w_HA = 1'b1;
            tick();
            check("halt_ignores_ha");
        end
        do_resume();
        run_op(4, 4, 1'b0, 2, 1'b0, 1'b0);

        run_op(2, 2, 1'b0, 99, 1'b0, 1'b0);
        run_op(7, 5, 1'b0, 1, 1'b0, 1'b0);
        if (m_halt) do_resume();
        run_op(13, 3, 1'b0, 2, 1'b1, 1'b1);

        bus.b_STAT_in = {3'd3, 5'd13};
        bus.w_HA = 1'b1;
        tick();
        tick();
        m_exec = 1'b1; m_we = 1'b1; m_op = 8'h08; m_line = 5'd13; m_skip = 1'b0;
        check("rst_exec_start");
        w_RST = 1'b1;
        tick();
        model_reset();
        check("rst_mid_op");
        check_state("rst_mid_op_state", ST_IDLE);
        w_RST = 1'b0;
        bus.w_HA = 1'b0;
        tick();
        check("post_rst_idle");

        for (int k = 0; k < 24; k++) begin
            run_op(int'($urandom_range(0, 31)), int'($urandom_range(0, 6)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            if (m_halt) do_resume();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
